ddk_chan_io: RTL and testbench
==============================

DDK_CHAN_IO -- requirements
Module: ddk_chan_io

Interface
REQ-001 Parameter NCH, default 8, number of channels; SHALL be even, >=2.
REQ-002 Parameter CHW, default 6, bits per channel.
REQ-003 Parameter SETTLE, default 4, self-test settle cycles; SHALL be >=3.
REQ-004 Parameter ERRW, default 16, error-counter width.
REQ-005 clk  in  1  system clock; one clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 core_out  in  NCH*CHW  core drive data; channel k at bits [k*CHW +: CHW].
REQ-008 core_oe  in  NCH*CHW  core per-bit output enable.
REQ-009 pad_in  in  NCH*CHW  raw pad input from the bidirectional buffers.
REQ-010 pad_out  out  NCH*CHW  registered drive data to the buffers.
REQ-011 pad_oe  out  NCH*CHW  registered output enable to the buffers.
REQ-012 core_in  out  NCH*CHW  synchronised pad input to the core.
REQ-013 test_start  in  1  single-cycle self-test request.
REQ-014 test_abort  in  1  self-test abort.
REQ-015 test_dir  in  1  0: even channels transmit to channel k+1; 1: odd channels transmit to channel k-1.
REQ-016 test_busy / test_done / test_pass  out  1 each  running / one-cycle completion pulse / result.
REQ-017 err_cnt  out  ERRW  saturating mismatch count; err_chan  out  clog2(NCH)  first failing receive channel.

Function
REQ-018 pad_in SHALL pass through a two-flop synchroniser; core_in lags pad_in by exactly 2 cycles, including during self-test.
REQ-019 When test_busy=0, pad_out/pad_oe SHALL equal core_out/core_oe delayed by exactly 1 cycle.
REQ-020 FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-021 IDLE->DRIVE on test_start=1; test_dir latched on the same edge; err_cnt, err_chan, test_pass cleared.
REQ-022 test_start while test_busy=1 SHALL be ignored.
REQ-023 Pattern sequence, index p = 0..2*CHW+1: walking-one bit 0..CHW-1, walking-zero bit 0..CHW-1, all-zeros, all-ones.
REQ-024 DRIVE (1 cycle): transmit channels drive pattern p with OE all-ones; receive channels have OE all-zeros; -> WAIT.
REQ-025 WAIT: SETTLE cycles, then -> CHECK.
REQ-026 CHECK (1 cycle): each receive channel's core_in is compared to pattern p; err_cnt += number of mismatching channels, saturating at 2^ERRW-1.
REQ-027 In CHECK, err_chan SHALL capture the lowest-index mismatching channel, but only if err_cnt was 0 before this CHECK.
REQ-028 CHECK -> DRIVE with p+1; after the last p, CHECK -> DONE.
REQ-029 DONE (1 cycle): test_done=1, test_pass=(err_cnt==0); -> IDLE.
REQ-030 test_pass SHALL hold until the next accepted test_start.
REQ-031 Total latency from the start edge to test_done high SHALL be (2*CHW+2)*(SETTLE+2)+1 cycles.
REQ-032 test_busy=1 in DRIVE, WAIT and CHECK; while busy, core_out/core_oe are ignored.
REQ-033 test_abort=1 in any busy state -> IDLE on that edge; no test_done; err_cnt retained; test_pass=0.
REQ-034 After an abort, pad outputs follow core on the next cycle.
REQ-035 test_abort and test_start in the same IDLE cycle: abort wins; the test does not start.

Reset
REQ-036 On rst_n low: pad_out, pad_oe, core_in and the synchronisers =0; all pads high-Z.
REQ-037 On rst_n low: test_busy, test_done, test_pass, err_cnt, err_chan =0; FSM=IDLE.
REQ-038 Reset mid-test SHALL abandon the test with no test_done.

Configuration
REQ-039 Macro DDK_CHAN_IO_SELFTEST_EN compiles in the FSM and comparator.
REQ-040 Without DDK_CHAN_IO_SELFTEST_EN: pass-through only; test inputs ignored; test outputs tied 0.

Structure
REQ-041 Package ddk_chio_pkg SHALL hold: FSM state enum; pattern-count constant function (2*CHW+2); pattern-generator function; clog2 helper.
REQ-042 Sub-module ddk_sync2: parametrised-width two-flop synchroniser with async active-low reset.

Verification (NCH=8, CHW=6, SETTLE=4, ERRW=16 unless noted)
REQ-043 Drive core_out ch0=0x2A, core_oe ch0=0x3F -> pad_out ch0=0x2A and pad_oe ch0=0x3F one cycle later; pad_in ch3=0x15 -> core_in ch3=0x15 two cycles later.
REQ-044 Ideal pair loopback model, test_dir=0, start -> test_done at cycle 85; test_pass=1; err_cnt=0.
REQ-045 Channel 5 bit 3 stuck-at-0, test_dir=0 -> err_cnt=7, err_chan=5, test_pass=0.
REQ-046 test_abort at cycle 20 of the test -> test_busy=0 next cycle; no test_done; pad_out follows core_out one cycle later.
REQ-047 rst_n low at cycle 30 of the test -> pad_oe=0, test_busy=0, err_cnt=0 immediately; test_start then runs a full test.
REQ-048 ERRW=2, all pads open (receive channels read 0) -> err_cnt saturates at 3; test_pass=0.

Source files
------------

// File: rtl/ddk_chio_pkg.sv
// ddk_chio_pkg: shared types and helpers for the ddk_chan_io pad block.
// Holds the self-test FSM state enum, the pattern count and pattern generator
// used by the loopback self-test, and a clog2 helper for port widths.
package ddk_chio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } chio_state_e;

  // Widest channel the pattern generator can describe.
  localparam int CHIO_PAT_MAXW = 32;

  // Ceiling log2 with a floor of 1 so the result is always a usable width.
  function automatic int chio_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  // Number of self-test patterns: walking-one, walking-zero, zeros, ones.
  function automatic int chio_num_patterns(input int chw);
    return 2 * chw + 2;
  endfunction

  // Pattern p for a chw-bit channel, right-aligned in a 32-bit word.
  function automatic logic [CHIO_PAT_MAXW-1:0] chio_pattern(input int p, input int chw);
    logic [CHIO_PAT_MAXW-1:0] mask;
    logic [CHIO_PAT_MAXW-1:0] pat;
    mask = (chw >= CHIO_PAT_MAXW) ? '1 : ((32'd1 << chw) - 32'd1);
    if (p < chw)
      pat = 32'd1 << p;
    else if (p < 2 * chw)
      pat = mask & ~(32'd1 << (p - chw));
    else if (p == 2 * chw)
      pat = '0;
    else
      pat = mask;
    return pat;
  endfunction

endpackage

// File: rtl/ddk_sync2.sv
// ddk_sync2: parametrised-width two-flop synchroniser, async active-low reset.
module ddk_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddk_chan_io.sv
// ddk_chan_io: registered bidirectional pad interface for NCH channels of CHW
// bits, with an optional pairwise loopback self-test.
// Build option: define DDK_CHAN_IO_SELFTEST_EN to compile in the self-test FSM
// and comparator; without it the block is a plain pass-through and the test
// outputs are tied low. Channel widths up to 32 bits are supported.
module ddk_chan_io
  import ddk_chio_pkg::*;
#(
  parameter int NCH    = 8,
  parameter int CHW    = 6,
  parameter int SETTLE = 4,
  parameter int ERRW   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH*CHW-1:0]           core_out,
  input  logic [NCH*CHW-1:0]           core_oe,
  input  logic [NCH*CHW-1:0]           pad_in,
  output logic [NCH*CHW-1:0]           pad_out,
  output logic [NCH*CHW-1:0]           pad_oe,
  output logic [NCH*CHW-1:0]           core_in,
  input  logic                         test_start,
  input  logic                         test_abort,
  input  logic                         test_dir,
  output logic                         test_busy,
  output logic                         test_done,
  output logic                         test_pass,
  output logic [ERRW-1:0]              err_cnt,
  output logic [chio_clog2(NCH)-1:0]   err_chan
);

  localparam int W  = NCH * CHW;
  localparam int CW = chio_clog2(NCH);

  logic [W-1:0] drv_out;
  logic [W-1:0] drv_oe;

  ddk_sync2 #(.W(W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_in),
    .q     (core_in)
  );

  // Register whatever the drive mux selects so the pads see clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_out <= '0;
      pad_oe  <= '0;
    end else begin
      pad_out <= drv_out;
      pad_oe  <= drv_oe;
    end
  end

`ifdef DDK_CHAN_IO_SELFTEST_EN

  localparam int NPAT = chio_num_patterns(CHW);
  localparam int PW   = chio_clog2(NPAT);
  localparam int SW   = chio_clog2(SETTLE);
  localparam int MW   = CW + 1;
  localparam int SUMW = ERRW + MW + 1;
  localparam logic [SUMW-1:0] ERR_MAX = {{(SUMW-ERRW){1'b0}}, {ERRW{1'b1}}};

  chio_state_e      state;
  chio_state_e      state_nxt;
  logic [PW-1:0]    pat_idx;
  logic [SW-1:0]    wait_cnt;
  logic             dir_q;
  logic [ERRW-1:0]  err_cnt_q;
  logic [CW-1:0]    err_chan_q;
  logic             pass_q;
  logic             done_q;
  logic             start_ok;
  logic             abort_now;
  logic             last_pat;
  logic [CHIO_PAT_MAXW-1:0] pat_wide;
  logic [CHW-1:0]   cur_pat;
  logic [MW-1:0]    mis_cnt;
  logic [CW-1:0]    first_mis;
  logic             any_mis;
  logic [SUMW-1:0]  err_sum;
  logic [ERRW-1:0]  err_next;

  assign test_busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
  assign start_ok  = (state == ST_IDLE) && test_start && !test_abort;
  assign abort_now = test_busy && test_abort;
  assign last_pat  = (pat_idx == PW'(NPAT - 1));
  assign pat_wide  = chio_pattern(int'(pat_idx), CHW);
  assign cur_pat   = pat_wide[CHW-1:0];

  if (CHW < CHIO_PAT_MAXW) begin : g_pat_hi
    logic unused_pat_hi;
    assign unused_pat_hi = ^pat_wide[CHIO_PAT_MAXW-1:CHW];
  end

  assign test_done = done_q;
  assign test_pass = pass_q;
  assign err_cnt   = err_cnt_q;
  assign err_chan  = err_chan_q;

  // Self-test state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an abort from any busy state wins over everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_DRIVE;
      ST_DRIVE: state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_cnt == SW'(SETTLE - 1)) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = last_pat ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_now) state_nxt = ST_IDLE;
  end

  // Pattern index, settle counter and latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_idx  <= '0;
      wait_cnt <= '0;
      dir_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        pat_idx <= '0;
        dir_q   <= test_dir;
      end else if (state == ST_CHECK && !last_pat) begin
        pat_idx <= pat_idx + 1'b1;
      end
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                  wait_cnt <= '0;
    end
  end

  // While busy, transmit channels drive the pattern and receivers float.
  always_comb begin
    drv_out = core_out;
    drv_oe  = core_oe;
    if (test_busy) begin
      for (int k = 0; k < NCH; k++) begin
        if ((k % 2) == int'(dir_q)) begin
          drv_out[k*CHW +: CHW] = cur_pat;
          drv_oe[k*CHW +: CHW]  = '1;
        end else begin
          drv_out[k*CHW +: CHW] = '0;
          drv_oe[k*CHW +: CHW]  = '0;
        end
      end
    end
  end

  // Count mismatching receivers and find the lowest one; saturate the total.
  always_comb begin
    mis_cnt   = '0;
    first_mis = '0;
    any_mis   = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if ((k % 2) != int'(dir_q) && core_in[k*CHW +: CHW] != cur_pat) begin
        mis_cnt   = mis_cnt + 1'b1;
        first_mis = CW'(k);
        any_mis   = 1'b1;
      end
    end
    err_sum  = SUMW'(err_cnt_q) + SUMW'(mis_cnt);
    err_next = (err_sum > ERR_MAX) ? {ERRW{1'b1}} : err_sum[ERRW-1:0];
  end

  // Result registers: cleared on start, updated in CHECK, resolved in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_chan_q <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (start_ok) begin
        err_cnt_q  <= '0;
        err_chan_q <= '0;
        pass_q     <= 1'b0;
      end else if (abort_now) begin
        pass_q <= 1'b0;
      end else if (state == ST_CHECK) begin
        err_cnt_q <= err_next;
        if (err_cnt_q == '0 && any_mis) err_chan_q <= first_mis;
      end else if (state == ST_DONE) begin
        pass_q <= (err_cnt_q == '0);
      end
    end
  end

`else

  logic unused_test_inputs;

  assign drv_out   = core_out;
  assign drv_oe    = core_oe;
  assign test_busy = 1'b0;
  assign test_done = 1'b0;
  assign test_pass = 1'b0;
  assign err_cnt   = '0;
  assign err_chan  = '0;
  assign unused_test_inputs = ^{test_start, test_abort, test_dir};

`endif

endmodule

// File: tb/tb_ddk_chan_io.sv
// tb_ddk_chan_io: directed + randomised bench for ddk_chan_io. Follows the
// DDK_CHAN_IO_SELFTEST_EN build option of the RTL it is compiled with.
module tb_ddk_chan_io;

  localparam int NCH    = 8;
  localparam int CHW    = 6;
  localparam int SETTLE = 4;
  localparam int ERRW   = 16;
  localparam int W      = NCH * CHW;
  localparam int NPAT   = 2 * CHW + 2;
  localparam int LAT    = NPAT * (SETTLE + 2) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0]  core_out, core_oe, pad_in, pad_out, pad_oe, core_in;
  logic          test_start, test_abort, test_dir;
  logic          test_busy, test_done, test_pass;
  logic [ERRW-1:0] err_cnt;
  logic [2:0]    err_chan;

  logic [W-1:0]  s_core_out, s_core_oe, s_pad_in, s_pad_out, s_pad_oe, s_core_in;
  logic          s_test_start, s_test_abort, s_test_dir;
  logic          s_test_busy, s_test_done, s_test_pass;
  logic [1:0]    s_err_cnt;
  logic [2:0]    s_err_chan;

  logic [W-1:0]  tb_pad_in;
  logic          loop_en, fault_en, fault_val;
  int            fault_ch, fault_bit;

  int checks   = 0;
  int failures = 0;

  ddk_chan_io #(.NCH(NCH), .CHW(CHW), .SETTLE(SETTLE), .ERRW(ERRW)) dut (
    .clk(clk), .rst_n(rst_n), .core_out(core_out), .core_oe(core_oe),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .core_in(core_in),
    .test_start(test_start), .test_abort(test_abort), .test_dir(test_dir),
    .test_busy(test_busy), .test_done(test_done), .test_pass(test_pass),
    .err_cnt(err_cnt), .err_chan(err_chan)
  );

  ddk_chan_io #(.NCH(NCH), .CHW(CHW), .SETTLE(SETTLE), .ERRW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .core_out(s_core_out), .core_oe(s_core_oe),
    .pad_in(s_pad_in), .pad_out(s_pad_out), .pad_oe(s_pad_oe), .core_in(s_core_in),
    .test_start(s_test_start), .test_abort(s_test_abort), .test_dir(s_test_dir),
    .test_busy(s_test_busy), .test_done(s_test_done), .test_pass(s_test_pass),
    .err_cnt(s_err_cnt), .err_chan(s_err_chan)
  );

  // Board model: paired channels share wires; an undriven wire reads 0.
  always_comb begin
    pad_in = tb_pad_in;
    if (loop_en) begin
      pad_in = '0;
      for (int k = 0; k < NCH; k++) begin
        for (int b = 0; b < CHW; b++) begin
          if (pad_oe[(k ^ 1) * CHW + b])  pad_in[k * CHW + b] = pad_out[(k ^ 1) * CHW + b];
          else if (pad_oe[k * CHW + b])   pad_in[k * CHW + b] = pad_out[k * CHW + b];
        end
      end
      if (fault_en) pad_in[fault_ch * CHW + fault_bit] = fault_val;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] co, input logic [W-1:0] oe, input logic [W-1:0] pin);
    core_out  = co;
    core_oe   = oe;
    tb_pad_in = pin;
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  // Reference pattern p, built straight from the pattern list.
  function automatic logic [CHW-1:0] ref_pattern(input int p);
    logic [CHW-1:0] v;
    v = '0;
    if (p < CHW) v[p] = 1'b1;
    else if (p < 2 * CHW) begin v = '1; v[p - CHW] = 1'b0; end
    else if (p == 2 * CHW) v = '0;
    else v = '1;
    return v;
  endfunction

  // Expected error count / first failing channel after npat patterns.
  function automatic void ref_selftest(input logic dir, input bit open_pads, input bit f_en,
                                       input int f_ch, input int f_bit, input logic f_val,
                                       input int npat, input int errw,
                                       output int exp_err, output int exp_chan);
    int total, maxv;
    bit seen, got;
    logic [CHW-1:0] pat, rcv;
    total = 0; seen = 0; exp_chan = 0;
    for (int p = 0; p < npat; p++) begin
      pat = ref_pattern(p);
      got = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        if ((dir == 1'b0) ? (ch % 2 == 1) : (ch % 2 == 0)) begin
          rcv = open_pads ? '0 : pat;
          if (f_en && ch == f_ch) rcv[f_bit] = f_val;
          if (rcv != pat) begin
            if (!seen && !got) begin exp_chan = ch; got = 1; end
            total++;
          end
        end
      end
      if (got) seen = 1;
    end
    maxv = (1 << errw) - 1;
    exp_err = (total > maxv) ? maxv : total;
  endfunction

`ifdef DDK_CHAN_IO_SELFTEST_EN
  // Full self-test on the main DUT; a stray start mid-test must be ignored.
  task automatic full_test(input string tag, input logic dir);
    int lat, e_err, e_chan;
    @(negedge clk); test_dir = dir; test_start = 1'b1;
    @(negedge clk); test_start = 1'b0; test_dir = ~dir;
    lat = 0;
    while (!test_done && lat < 300) begin
      @(negedge clk);
      lat++;
      test_start = (lat == 40);
    end
    test_start = 1'b0;
    ref_selftest(dir, 0, fault_en, fault_ch, fault_bit, fault_val, NPAT, ERRW, e_err, e_chan);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(LAT));
    checkOutput({tag, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
    checkOutput({tag, "_err_chan"}, 64'(err_chan), 64'(e_chan));
    checkOutput({tag, "_pass"}, 64'(test_pass), 64'(e_err == 0));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(test_done), 64'(0));
    checkOutput({tag, "_busy_after"}, 64'(test_busy), 64'(0));
  endtask
`endif

  initial begin
    logic [W-1:0] co, oe, pin, exp_out, exp_oe, pin_d1, pin_d2;
    int e_err, e_chan, lat, dones;

    rst_n = 1'b0;
    test_start = 0; test_abort = 0; test_dir = 0;
    s_test_start = 0; s_test_abort = 0; s_test_dir = 0;
    s_core_out = '0; s_core_oe = '0; s_pad_in = '0;
    loop_en = 0; fault_en = 0; fault_val = 0; fault_ch = 0; fault_bit = 0;
    applyStimulus(rnd_w(), rnd_w(), rnd_w());
    @(negedge clk); @(negedge clk);
    checkOutput("rst_pad_out", 64'(pad_out), 64'(0));
    checkOutput("rst_pad_oe", 64'(pad_oe), 64'(0));
    checkOutput("rst_core_in", 64'(core_in), 64'(0));
    checkOutput("rst_flags", 64'({test_busy, test_done, test_pass}), 64'(0));
    checkOutput("rst_err", 64'({err_cnt, err_chan}), 64'(0));
    rst_n = 1'b1;

    // Directed pass-through: ch0 drive, ch3 receive.
    co = '0; co[5:0] = 6'h2A; oe = '0; oe[5:0] = 6'h3F;
    pin = '0; pin[3*CHW +: CHW] = 6'h15;
    applyStimulus(co, oe, pin);
    @(negedge clk);
    checkOutput("pt_ch0_out", 64'(pad_out[5:0]), 64'h2A);
    checkOutput("pt_ch0_oe", 64'(pad_oe[5:0]), 64'h3F);
    checkOutput("pt_ch3_in_1cyc", 64'(core_in[3*CHW +: CHW]), 64'h0);
    @(negedge clk);
    checkOutput("pt_ch3_in_2cyc", 64'(core_in[3*CHW +: CHW]), 64'h15);

    // Randomised pass-through: 1-cycle drive lag, 2-cycle receive lag.
    exp_out = co; exp_oe = oe; pin_d1 = pin; pin_d2 = pin;
    for (int i = 0; i < 12; i++) begin
      co = rnd_w(); oe = rnd_w(); pin = rnd_w();
      applyStimulus(co, oe, pin);
      @(negedge clk);
      checkOutput("pt_rand_out", 64'(pad_out), 64'(co));
      checkOutput("pt_rand_oe", 64'(pad_oe), 64'(oe));
      pin_d2 = pin_d1; pin_d1 = pin;
      if (i > 0) checkOutput("pt_rand_in", 64'(core_in), 64'(pin_d2));
    end

`ifdef DDK_CHAN_IO_SELFTEST_EN
    applyStimulus('0, '0, '0);
    loop_en = 1;
    @(negedge clk); @(negedge clk);

    full_test("ideal", 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pass_hold", 64'(test_pass), 64'(1));

    fault_en = 1; fault_ch = 5; fault_bit = 3; fault_val = 0;
    full_test("stuck5_3", 1'b0);
    checkOutput("stuck5_3_cnt_const", 64'(err_cnt), 64'(7));
    checkOutput("stuck5_3_chan_const", 64'(err_chan), 64'(5));

    for (int i = 0; i < 3; i++) begin
      fault_ch = $urandom_range(0, NCH - 1);
      fault_bit = $urandom_range(0, CHW - 1);
      fault_val = 1'($urandom_range(0, 1));
      full_test("rand_fault", 1'($urandom_range(0, 1)));
    end

    // Abort at cycle 20 with a fault that fails the very first pattern.
    fault_ch = 1; fault_bit = 0; fault_val = 0;
    @(negedge clk); test_dir = 0; test_start = 1;
    @(negedge clk); test_start = 0;
    repeat (19) @(negedge clk);
    co = rnd_w(); oe = rnd_w();
    applyStimulus(co, oe, '0);
    test_abort = 1;
    @(negedge clk); test_abort = 0;
    checkOutput("abort_busy", 64'(test_busy), 64'(0));
    checkOutput("abort_pass", 64'(test_pass), 64'(0));
    ref_selftest(0, 0, 1, 1, 0, 0, 20 / (SETTLE + 2), ERRW, e_err, e_chan);
    checkOutput("abort_err_kept", 64'(err_cnt), 64'(e_err));
    @(negedge clk);
    checkOutput("abort_pad_out", 64'(pad_out), 64'(co));
    checkOutput("abort_pad_oe", 64'(pad_oe), 64'(oe));
    applyStimulus('0, '0, '0);
    dones = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); dones += int'(test_done); end
    checkOutput("abort_no_done", 64'(dones), 64'(0));

    // Reset at cycle 30 of a faulty test.
    fault_ch = 5; fault_bit = 3; fault_val = 0;
    @(negedge clk); test_dir = 0; test_start = 1;
    @(negedge clk); test_start = 0;
    repeat (30) @(negedge clk);
    ref_selftest(0, 0, 1, 5, 3, 0, 30 / (SETTLE + 2), ERRW, e_err, e_chan);
    checkOutput("prereset_err", 64'(err_cnt), 64'(e_err));
    rst_n = 0;
    #1;
    checkOutput("midrst_pad_oe", 64'(pad_oe), 64'(0));
    checkOutput("midrst_busy", 64'(test_busy), 64'(0));
    checkOutput("midrst_err", 64'(err_cnt), 64'(0));
    @(negedge clk); rst_n = 1;
    dones = 0;
    for (int i = 0; i < 90; i++) begin @(negedge clk); dones += int'(test_done); end
    checkOutput("midrst_no_done", 64'(dones), 64'(0));
    fault_en = 0;
    full_test("after_reset", 1'b1);

    // Saturation on the ERRW=2 instance with open pads.
    @(negedge clk); s_test_start = 1;
    @(negedge clk); s_test_start = 0;
    lat = 0;
    while (!s_test_done && lat < 300) begin @(negedge clk); lat++; end
    ref_selftest(0, 1, 0, 0, 0, 0, NPAT, 2, e_err, e_chan);
    checkOutput("sat_latency", 64'(lat), 64'(LAT));
    checkOutput("sat_err_cnt", 64'(s_err_cnt), 64'(e_err));
    checkOutput("sat_err_chan", 64'(s_err_chan), 64'(e_chan));
    checkOutput("sat_pass", 64'(s_test_pass), 64'(0));
`else
    // Without the self-test the test inputs do nothing.
    @(negedge clk); test_start = 1; s_test_start = 1;
    @(negedge clk); test_start = 0; s_test_start = 0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      dones += int'(test_busy) + int'(test_done) + int'(s_test_busy) + int'(s_test_done);
    end
    checkOutput("nost_no_activity", 64'(dones), 64'(0));
    checkOutput("nost_outputs", 64'({test_pass, err_cnt, err_chan}), 64'(0));
    checkOutput("nost_pad_out", 64'(pad_out), 64'(core_out));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
